// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//
// Turns a raster-order pixel stream into KERNEL x KERNEL windows for the conv
// layer calculation block. It covers every valid output position: there is no
// padding and the stride is 1.
//
// The block keeps KERNEL-1 line buffers. Each buffer is a circular array of
// depth IMG_W, indexed by column. It also keeps a KERNEL x KERNEL shift
// window. On each accepted pixel, a new column enters the window on the
// right. That column is the incoming pixel plus the pixels at the same column
// in the previous KERNEL-1 rows, read from the line buffers.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   pix_in      pixel data, qualified by en_in
//   en_in       pixel valid, one pixel per cycle
//   sof         start of frame (with en_in): pixel is (0,0); restarts if active
//   data2conv   packed window, element r*KERNEL+c at [e*N +: N]
//               (r=0 is the top row, c=0 is the leftmost column)
//   en_out      one-cycle strobe, data2conv valid
//   frame_done  one-cycle pulse, coincident with the last en_out of a frame
//
// Optional feature, macro CONV_WIN_GEN_COORD_EN:
//   win_row     top-left row of the emitted window
//   win_col     top-left column of the emitted window
// ---------------------------------------------------------------------------
module conv_window_gen #(
   parameter int KERNEL = 3,
   parameter int N      = 4,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               pix_in,
   input  logic                       en_in,
   input  logic                       sof,
   output logic [KERNEL*KERNEL*N-1:0] data2conv,
   output logic                       en_out,
   output logic                       frame_done
`ifdef CONV_WIN_GEN_COORD_EN
   ,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic [$clog2(IMG_W)-1:0]   win_col
`endif
);

   localparam int DW = KERNEL * KERNEL * N;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int LB = (KERNEL > 1) ? KERNEL - 1 : 1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d, cur_col;
   logic [RW-1:0]   row_q, row_d, cur_row;
   logic            accept, emit, last_pix, col_last;
   logic            en_out_q, frame_done_q;
   logic [DW-1:0]   data2conv_q, win_packed;

   logic [N-1:0]    win_q   [KERNEL][KERNEL];
   logic [N-1:0]    win_d   [KERNEL][KERNEL];
   logic [N-1:0]    new_col [KERNEL];
   logic [N-1:0]    lb_rd   [LB];

   genvar gi, gj;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (accept) state_d = last_pix ? IDLE : ACTIVE;
   end

   // ------------------------------------------------------------------
   // FSM outputs: pixel acceptance, its coordinate, and counter update.
   // When sof is asserted, the pixel is forced to (0,0), whether or not a
   // frame was in progress. Because the row/col gating restarts with it,
   // stale line-buffer data from an aborted frame can never reach a window.
   // ------------------------------------------------------------------
   always_comb begin
      accept   = en_in && (sof || (state_q == ACTIVE));
      cur_col  = sof ? '0 : col_q;
      cur_row  = sof ? '0 : row_q;
      col_last = (cur_col == CW'(IMG_W - 1));
      last_pix = accept && col_last && (cur_row == RW'(IMG_H - 1));
      emit     = accept && (int'(cur_row) >= KERNEL - 1)
                        && (int'(cur_col) >= KERNEL - 1);
      col_d    = col_q;
      row_d    = row_q;
      if (accept) begin
         if (last_pix) begin
            col_d = '0;
            row_d = '0;
         end else if (col_last) begin
            col_d = '0;
            row_d = cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end
   end

   // ------------------------------------------------------------------
   // Line buffers. Buffer 0 holds the previous row. Buffer k holds the row
   // k+1 above the current one, so on each write every buffer passes its
   // old value down the chain. The read is combinational, so the old value
   // is seen before the write that happens in the same cycle.
   // ------------------------------------------------------------------
   generate
      if (KERNEL > 1) begin : g_lb
         for (gi = 0; gi < KERNEL - 1; gi++) begin : g_buf
            logic [N-1:0] mem [IMG_W];
            logic [N-1:0] wr_data;

            assign lb_rd[gi] = mem[cur_col];

            if (gi == 0) begin : g_first
               assign wr_data = pix_in;
            end else begin : g_chain
               assign wr_data = lb_rd[gi-1];
            end

            always_ff @(posedge clk) begin
               if (accept) mem[cur_col] <= wr_data;
            end
         end
      end else begin : g_no_lb
         assign lb_rd[0] = '0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Incoming column. The bottom row is the live pixel; each row above it
   // comes from one line buffer further back.
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < KERNEL; gi++) begin : g_newcol
         if (gi == KERNEL - 1) begin : g_live
            assign new_col[gi] = pix_in;
         end else begin : g_buf
            assign new_col[gi] = lb_rd[KERNEL-2-gi];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next window: shift left and append the new column. The packed form of
   // this next window is what gets captured into data2conv.
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < KERNEL; gi++) begin : g_wrow
         for (gj = 0; gj < KERNEL; gj++) begin : g_wcol
            if (gj < KERNEL - 1) begin : g_shift
               assign win_d[gi][gj] = win_q[gi][gj+1];
            end else begin : g_append
               assign win_d[gi][gj] = new_col[gi];
            end
            assign win_packed[(gi*KERNEL+gj)*N +: N] = win_d[gi][gj];
         end
      end
   endgenerate

   // The window contents are data-path only; they are never emitted before
   // they have been refilled by the current frame, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept) win_q <= win_d;
   end

   // ------------------------------------------------------------------
   // Counters and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         en_out_q     <= 1'b0;
         frame_done_q <= 1'b0;
         data2conv_q  <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         en_out_q     <= emit;
         frame_done_q <= last_pix;
         if (emit) data2conv_q <= win_packed;
      end
   end

   assign data2conv  = data2conv_q;
   assign en_out     = en_out_q;
   assign frame_done = frame_done_q;

`ifdef CONV_WIN_GEN_COORD_EN
   localparam int CRW = $clog2(IMG_H);
   localparam int CCW = $clog2(IMG_W);

   logic [CRW-1:0] win_row_q;
   logic [CCW-1:0] win_col_q;

   // The window coordinate is its top-left corner, which is the completing
   // pixel's coordinate minus KERNEL-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (emit) begin
         win_row_q <= CRW'(int'(cur_row) - (KERNEL - 1));
         win_col_q <= CCW'(int'(cur_col) - (KERNEL - 1));
      end
   end

   assign win_row = win_row_q;
   assign win_col = win_col_q;
`endif

endmodule
